// File: rtl/s_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// s_mem_arb_pkg
// Shared definitions for the single-port memory arbiter:
//   - state_e            : arbiter FSM states (IDLE = no owner, OWNED = one owner)
//   - DEFAULT_DATA_WIDTH : default address/data width of the shared RAM
//   - DEFAULT_N_REQ      : default number of requesters (init, KSA, PRGA)
// -----------------------------------------------------------------------------
package s_mem_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_N_REQ      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

endpackage

// File: rtl/s_mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection. Scans the request vector starting at
// start_i and wrapping modulo N_REQ; the first requester found wins.
// Ports:
//   req_i   [N_REQ-1:0] : request vector
//   start_i [IDX_W-1:0] : index where the search begins (must be < N_REQ)
//   win_o   [N_REQ-1:0] : one-hot winner, zero when req_i is zero
// -----------------------------------------------------------------------------
module arb_pick #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N_REQ-1:0] win_o
);

  // Walk from the farthest offset back to the nearest so that the nearest
  // requesting index is the last (and therefore surviving) assignment.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first; otherwise a
    // path that skips the assignment would infer a latch.
    win_o = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(start_i) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// s_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between N_REQ
// requesters. An owner keeps the RAM for as long as it holds its req high;
// on release there is always exactly one idle turnaround cycle before the
// next grant.
//
// Configuration:
//   MEM_ARB_RR_EN defined   : round-robin, search starts after last grantee
//   MEM_ARB_RR_EN undefined : fixed priority, lowest index wins
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req      [N]         : per-requester request, held for the whole tenure
//   gnt      [N]         : registered one-hot-or-zero grant
//   m_addr   [N*DW]      : per-requester address, requester i at [i*DW +: DW]
//   m_data   [N*DW]      : per-requester write data, packed like m_addr
//   m_wren   [N]         : per-requester write enable
//   m_q      [DW]        : RAM read data broadcast to all requesters
//   m_rvalid [N]         : m_q valid for requester i (registered pulse)
//   mem_address/mem_data/mem_wren/mem_q : RAM port
// -----------------------------------------------------------------------------
module s_mem_arbiter
  import s_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_REQ      = DEFAULT_N_REQ
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  output logic [N_REQ-1:0]            gnt,
  input  logic [N_REQ*DATA_WIDTH-1:0] m_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] m_data,
  input  logic [N_REQ-1:0]            m_wren,
  output logic [DATA_WIDTH-1:0]       m_q,
  output logic [N_REQ-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]       mem_address,
  output logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        mem_wren,
  input  logic [DATA_WIDTH-1:0]       mem_q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rvalid_q;
  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] start_idx;
  logic             owner_req;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Search begins one past the last grantee; pointer resets to 0, so the
  // first search after reset begins at index 1.
  always_comb begin
    start_idx = (ptr_q == IDX_W'(N_REQ - 1)) ? '0 : ptr_q + 1'b1;
    ptr_d     = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) ptr_d = IDX_W'(i);
    end
  end
`else
  assign start_idx = '0;
`endif

  arb_pick #(
    .N_REQ (N_REQ)
  ) u_arb_pick (
    .req_i   (req),
    .start_i (start_idx),
    .win_o   (win)
  );

  // Owner still holding its request (gnt_q is one-hot or zero).
  assign owner_req = |(gnt_q & req);

  // NOTE: sequential state is updated with non-blocking assignments only so
  // every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      // A read accepted this cycle returns data next cycle, even if the
      // owner releases now (the pulse lands in the turnaround cycle).
      rvalid_q <= gnt_q & req & ~m_wren;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= win;
            state_q <= OWNED;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
          end
        end
        OWNED: begin
          // Other requests are ignored; release always passes through IDLE.
          if (!owner_req) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM port mux: everything is zero while nobody holds the grant, which
  // also truncates a write burst as soon as reset clears gnt.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        mem_address = m_addr[i*DATA_WIDTH +: DATA_WIDTH];
        mem_data    = m_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_wren    = req[i] & m_wren[i];
      end
    end
  end

  assign m_q      = mem_q;
  assign gnt      = gnt_q;
  assign m_rvalid = rvalid_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_mem_arbiter
// Directed and randomized stimulus for s_mem_arbiter with a 256x8 RAM model
// attached to the memory port. A behavioural reference (owner index, last
// grantee, expected RAM contents) predicts grant, read-valid, read data and
// the RAM port mux every cycle.
// -----------------------------------------------------------------------------
module tb_s_mem_arbiter;

  localparam int DW = 8;
  localparam int N  = 3;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N*DW-1:0] m_addr;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_wren;
  logic [DW-1:0]   m_q;
  logic [N-1:0]    m_rvalid;
  logic [DW-1:0]   mem_address;
  logic [DW-1:0]   mem_data;
  logic            mem_wren;
  logic [DW-1:0]   mem_q;

  logic [DW-1:0]   a [N];
  logic [DW-1:0]   d [N];

  assign m_addr = {a[2], a[1], a[0]};
  assign m_data = {d[2], d[1], d[0]};

  s_mem_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_wren      (m_wren),
    .m_q         (m_q),
    .m_rvalid    (m_rvalid),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // Single-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state
  int            checks   = 0;
  int            failures = 0;
  int            owner    = -1;
  int            last     = 0;
  int            wcount   = 0;
  logic [DW-1:0] model_ram [256];
  logic [DW-1:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int s;
    int idx;
    s = RR ? (last + 1) % N : 0;
    for (int k = 0; k < N; k++) begin
      idx = (s + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: check the RAM port mux mid-cycle, advance the model at
  // the edge, then check registered outputs just after the edge.
  task automatic cycle();
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    if (owner >= 0) begin
      check("mem_address", 32'(mem_address), 32'(a[owner]));
      check("mem_data",    32'(mem_data),    32'(d[owner]));
      check("mem_wren",    32'(mem_wren),    32'(req[owner] & m_wren[owner]));
    end else begin
      check("mem_address_idle", 32'(mem_address), 32'd0);
      check("mem_data_idle",    32'(mem_data),    32'd0);
      check("mem_wren_idle",    32'(mem_wren),    32'd0);
    end
    if (mem_wren) wcount++;
    @(posedge clk);
    exp_rv = '0;
    if (owner >= 0 && req[owner]) begin
      if (m_wren[owner]) model_ram[a[owner]] = d[owner];
      else begin
        exp_rv[owner] = 1'b1;
        exp_rdata     = model_ram[a[owner]];
      end
    end
    if (rst) begin
      exp_rv = '0;
      owner  = -1;
      last   = 0;
    end else if (owner < 0) begin
      owner = pick(req);
      if (owner >= 0) last = owner;
    end else if (!req[owner]) begin
      owner = -1;
    end
    #1;
    exp_gnt = (owner >= 0) ? N'(1 << owner) : '0;
    check("gnt",      32'(gnt),      32'(exp_gnt));
    check("m_rvalid", 32'(m_rvalid), 32'(exp_rv));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (exp_rv != '0) check("m_q", 32'(m_q), 32'(exp_rdata));
  endtask

  task automatic idle_inputs();
    req    = '0;
    m_wren = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
  endtask

  logic [N-1:0] seq [5];

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 256; k++) model_ram[k] = 'x;
    // Unchecked settle edges: DUT state is unknown before the first reset.
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check("reset_gnt",    32'(gnt),      32'd0);
    check("reset_rvalid", 32'(m_rvalid), 32'd0);
    rst = 1'b0;

    // Fill: requester 0 writes data = addr over the whole address space.
    req = 3'b001;
    cycle();
    check("fill_grant", 32'(gnt), 32'b001);
    wcount = 0;
    for (int k = 0; k < 256; k++) begin
      m_wren[0] = 1'b1;
      a[0]      = 8'(k);
      d[0]      = 8'(k);
      cycle();
    end
    check("fill_pulses", 32'(wcount), 32'd256);
    for (int k = 0; k < 256; k++) check("fill_ram", 32'(ram[k]), 32'(k));

    // Read back address 5 while still owning.
    m_wren[0] = 1'b0;
    a[0]      = 8'h05;
    cycle();
    check("read5_rvalid", 32'(m_rvalid), 32'b001);
    check("read5_q",      32'(m_q),      32'h05);
    idle_inputs();
    cycle();
    check("release_gnt", 32'(gnt), 32'd0);

    // Last-cycle write: write presented, then req drops immediately after.
    req = 3'b001;
    cycle();
    m_wren[0] = 1'b1;
    a[0]      = 8'h10;
    d[0]      = 8'hAA;
    cycle();
    req    = 3'b000;
    m_wren = 3'b000;
    cycle();
    check("lastwr_gnt", 32'(gnt), 32'd0);
    check("lastwr_ram", 32'(ram[8'h10]), 32'hAA);

    // Requester 1 owns; requester 2 arrives mid-tenure and must wait.
    req = 3'b010;
    cycle();
    check("own1_gnt", 32'(gnt), 32'b010);
    req = 3'b110;
    repeat (3) begin
      cycle();
      check("own1_hold", 32'(gnt), 32'b010);
    end
    req = 3'b100;
    cycle();
    check("own1_turn", 32'(gnt), 32'b000);
    cycle();
    check("own2_gnt", 32'(gnt), 32'b100);
    idle_inputs();
    cycle();

    // All requesting, each owner releases after two cycles.
    if (RR) begin
      seq[0] = 3'b010; seq[1] = 3'b000; seq[2] = 3'b100; seq[3] = 3'b000; seq[4] = 3'b001;
    end else begin
      seq[0] = 3'b001; seq[1] = 3'b000; seq[2] = 3'b001; seq[3] = 3'b000; seq[4] = 3'b001;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = 3'b111;
    cycle();
    check("rr_seq0", 32'(gnt), 32'(seq[0]));
    for (int g = 0; g < 2; g++) begin
      cycle();
      if (owner >= 0) req[owner] = 1'b0;
      cycle();
      check("rr_seq_idle", 32'(gnt), 32'(seq[2*g+1]));
      req = 3'b111;
      cycle();
      check("rr_seq_next", 32'(gnt), 32'(seq[2*g+2]));
    end
    idle_inputs();
    cycle();

    // Reset in the middle of a write burst at 0x3E..0x40.
    req = 3'b001;
    cycle();
    m_wren[0] = 1'b1;
    d[0]      = 8'hEE;
    for (int k = 8'h3E; k <= 8'h40; k++) begin
      a[0] = 8'(k);
      if (k == 8'h40) rst = 1'b1;
      cycle();
    end
    rst  = 1'b0;
    a[0] = 8'h41;
    check("rst_burst_gnt", 32'(gnt), 32'd0);
    cycle();
    check("rst_burst_ram40", 32'(ram[8'h40]), 32'hEE);
    check("rst_burst_ram41", 32'(ram[8'h41]), 32'h41);
    idle_inputs();
    cycle();

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      req    = N'($urandom);
      m_wren = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = 8'($urandom);
        d[i] = 8'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();
    for (int k = 0; k < 256; k++) check("final_ram", 32'(ram[k]), 32'(model_ram[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
